// File: rtl/placement_pkg.sv
// Shared definitions for the placement checker: FSM state encoding, error
// flag bit positions and default grid / netlist sizes.
package placement_pkg;

    // Default configuration
    localparam int unsigned DefN     = 4;
    localparam int unsigned DefNNode = 14;
    localparam int unsigned DefNEdge = 15;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StEval = 2'd2;
    localparam state_t StDone = 2'd3;

    // Bit positions within the sticky err vector
    localparam int unsigned ErrOob      = 0;
    localparam int unsigned ErrOverlap  = 1;
    localparam int unsigned ErrDup      = 2;
    localparam int unsigned ErrBadId    = 3;
    localparam int unsigned ErrUnplaced = 4;

endpackage

// File: rtl/placement_edge_cost.sv
// Manhattan distance between two cells and the wirelength contribution of an
// edge (distance minus one, floored at zero). Purely combinational.
module placement_edge_cost #(
    parameter int unsigned CW = 3
) (
    input  logic [CW-1:0] xa_i,
    input  logic [CW-1:0] ya_i,
    input  logic [CW-1:0] xb_i,
    input  logic [CW-1:0] yb_i,
    output logic [CW:0]   d_o,
    output logic [CW:0]   cost_o
);

    logic [CW-1:0] dx;
    logic [CW-1:0] dy;

    // Absolute differences, distance and cost
    always_comb begin
        dx     = (xa_i >= xb_i) ? (xa_i - xb_i) : (xb_i - xa_i);
        dy     = (ya_i >= yb_i) ? (ya_i - yb_i) : (yb_i - ya_i);
        d_o    = {1'b0, dx} + {1'b0, dy};
        cost_o = (d_o == '0) ? '0 : (d_o - 1'b1);
    end

endmodule

// File: rtl/placement_check.sv
// Placement legality checker and wirelength estimator.
// Loads N_NODE node positions onto an N x N grid, then streams N_EDGE edges
// and accumulates their cost. Optional feature macro PLACEMENT_CHECK_MAXLEN_EN
// adds a max_len output tracking the longest valid edge distance of a run.
module placement_check
    import placement_pkg::*;
#(
    parameter int unsigned N      = DefN,
    parameter int unsigned N_NODE = DefNNode,
    parameter int unsigned N_EDGE = DefNEdge
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pos_valid,
    output logic                      pos_ready,
    input  logic [$clog2(N_NODE)-1:0] pos_node,
    input  logic [$clog2(N):0]        pos_x,
    input  logic [$clog2(N):0]        pos_y,
    input  logic                      edge_valid,
    output logic                      edge_ready,
    input  logic [$clog2(N_NODE)-1:0] edge_a,
    input  logic [$clog2(N_NODE)-1:0] edge_b,
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                err,
    output logic [15:0]               wirelength
`ifdef PLACEMENT_CHECK_MAXLEN_EN
    ,
    output logic [7:0]                max_len
`endif
);

    localparam int unsigned NW   = $clog2(N_NODE);
    localparam int unsigned CW   = $clog2(N) + 1;
    localparam int unsigned CIW  = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int unsigned NIDX = 1 << NW;
    localparam int unsigned PCW  = $clog2(N_NODE + 1);
    localparam int unsigned ECW  = $clog2(N_EDGE + 1);

    state_t           state_q, state_d;
    logic [PCW-1:0]   pos_cnt_q, pos_cnt_d;
    logic [ECW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [NIDX-1:0]  placed_q, placed_d;
    logic [N*N-1:0]   occ_q, occ_d;
    logic [4:0]       err_q, err_d;
    logic [15:0]      wl_q, wl_d;
    logic             cost_vld_q, cost_vld_d;
    logic [CW:0]      cost_q, cost_d;
    logic [CW-1:0]    x_q [NIDX];
    logic [CW-1:0]    y_q [NIDX];

    logic             tbl_we;
    logic             pos_fire, edge_fire;
    logic             node_ok, cell_ok, ends_ok;
    logic [CIW-1:0]   cell_idx;
    logic [CW:0]      edge_d, edge_cost;
    logic [16:0]      wl_sum;

`ifdef PLACEMENT_CHECK_MAXLEN_EN
    logic [CW:0]      len_q, len_d;
    logic [7:0]       max_q, max_d;
    logic [7:0]       len_sat;
`else
    logic             unused_len;
    assign unused_len = ^edge_d;
`endif

    assign pos_ready  = (state_q == StLoad);
    assign edge_ready = (state_q == StEval);
    assign busy       = (state_q == StLoad) || (state_q == StEval);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign wirelength = wl_q;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
    assign max_len    = max_q;
`endif

    // Endpoint coordinates come straight from the table in the accept cycle
    placement_edge_cost #(
        .CW (CW)
    ) u_cost (
        .xa_i   (x_q[edge_a]),
        .ya_i   (y_q[edge_a]),
        .xb_i   (x_q[edge_b]),
        .yb_i   (y_q[edge_b]),
        .d_o    (edge_d),
        .cost_o (edge_cost)
    );

    // Handshake qualifiers and position / endpoint legality
    always_comb begin
        pos_fire  = pos_valid && pos_ready;
        // Extra edges offered after the last one are not taken
        edge_fire = edge_valid && edge_ready && (edge_cnt_q < ECW'(N_EDGE));
        node_ok   = {1'b0, pos_node} < (NW + 1)'(N_NODE);
        cell_ok   = (pos_x < CW'(N)) && (pos_y < CW'(N));
        cell_idx  = CIW'(32'(pos_x) * N + 32'(pos_y));
        // placed bits are only ever set for in-range ids
        ends_ok   = placed_q[edge_a] && placed_q[edge_b];
        wl_sum    = 17'(wl_q) + 17'(cost_q);
`ifdef PLACEMENT_CHECK_MAXLEN_EN
        len_sat   = (32'(len_q) > 32'd255) ? 8'hFF : 8'(len_q);
`endif
    end

    // Next-state: FSM, counters, occupancy, error flags and accumulation
    always_comb begin
        state_d    = state_q;
        pos_cnt_d  = pos_cnt_q;
        edge_cnt_d = edge_cnt_q;
        placed_d   = placed_q;
        occ_d      = occ_q;
        err_d      = err_q;
        wl_d       = wl_q;
        cost_vld_d = 1'b0;
        cost_d     = '0;
        tbl_we     = 1'b0;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
        len_d      = '0;
        max_d      = max_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StLoad;
                    pos_cnt_d  = '0;
                    edge_cnt_d = '0;
                    placed_d   = '0;
                    occ_d      = '0;
                    err_d      = '0;
                    wl_d       = '0;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
                    max_d      = '0;
`endif
                end
            end
            StLoad: begin
                if (pos_fire) begin
                    pos_cnt_d = pos_cnt_q + 1'b1;
                    if (!node_ok) begin
                        err_d[ErrBadId] = 1'b1;
                    end else if (!cell_ok) begin
                        err_d[ErrOob] = 1'b1;
                    end else if (placed_q[pos_node]) begin
                        err_d[ErrDup] = 1'b1;
                    end else if (occ_q[cell_idx]) begin
                        err_d[ErrOverlap] = 1'b1;
                    end else begin
                        tbl_we             = 1'b1;
                        placed_d[pos_node] = 1'b1;
                        occ_d[cell_idx]    = 1'b1;
                    end
                    // Every beat counts, legal or not
                    if (pos_cnt_q == PCW'(N_NODE - 1)) begin
                        state_d = StEval;
                    end
                end
            end
            StEval: begin
                if (cost_vld_q) begin
                    wl_d = wl_sum[16] ? 16'hFFFF : wl_sum[15:0];
`ifdef PLACEMENT_CHECK_MAXLEN_EN
                    if (len_sat > max_q) begin
                        max_d = len_sat;
                    end
`endif
                    // The final edge's cost lands in the same cycle we leave
                    if (edge_cnt_q == ECW'(N_EDGE)) begin
                        state_d = StDone;
                    end
                end
                if (edge_fire) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    cost_vld_d = 1'b1;
                    if (ends_ok) begin
                        cost_d = edge_cost;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
                        len_d  = edge_d;
`endif
                    end else begin
                        err_d[ErrUnplaced] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pos_cnt_q  <= '0;
            edge_cnt_q <= '0;
            placed_q   <= '0;
            occ_q      <= '0;
            err_q      <= '0;
            wl_q       <= '0;
            cost_vld_q <= 1'b0;
            cost_q     <= '0;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
            len_q      <= '0;
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pos_cnt_q  <= pos_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            placed_q   <= placed_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
            wl_q       <= wl_d;
            cost_vld_q <= cost_vld_d;
            cost_q     <= cost_d;
`ifdef PLACEMENT_CHECK_MAXLEN_EN
            len_q      <= len_d;
            max_q      <= max_d;
`endif
        end
    end

    // Position table; entries are only meaningful while their placed bit is set
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            x_q[pos_node] <= pos_x;
            y_q[pos_node] <= pos_y;
        end
    end

endmodule
